// File: rtl/mmio_timer_v1.sv
// Memory-mapped timer: prescaled 32-bit up-counter with compare match, overflow
// detect and a level interrupt, serviced through a 1 KiB MMIO slot.
module mmio_timer_v1 #(
  parameter logic [31:0] ID_VALUE = 32'h544D5231
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic [31:0] data_address,
  input  logic [31:0] data_store,
  input  logic        data_read,
  input  logic        data_enable,
  output logic [31:0] data_fetch,
  output logic        irq
);

  localparam logic [7:0] OFF_CTRL    = 8'h00;
  localparam logic [7:0] OFF_COUNT   = 8'h01;
  localparam logic [7:0] OFF_COMPARE = 8'h02;
  localparam logic [7:0] OFF_STATUS  = 8'h03;
  localparam logic [7:0] OFF_ID      = 8'h04;

  logic        en_r, auto_r, irq_en_r;
  logic [7:0]  prescale_r;
  logic [7:0]  pcnt_r;
  logic [31:0] count_r, compare_r;
  logic        match_r, ovf_r;
  logic [31:0] data_fetch_r;
  logic        irq_r;

  logic        acc_s, wr_s, rd_s;
  logic [7:0]  off_s;
  logic        wr_ctrl_s, wr_count_s, wr_compare_s, wr_status_s;
  logic        tick_s, hit_s, match_set_s, ovf_set_s;
  logic [31:0] count_next_s;
  logic [31:0] rdata_s;
  logic        unused_addr_s;

  assign acc_s         = sel & data_enable;
  assign wr_s          = acc_s & ~data_read;
  assign rd_s          = acc_s & data_read;
  assign off_s         = data_address[9:2];
  assign unused_addr_s = ^{data_address[31:10], data_address[1:0]};

  assign wr_ctrl_s    = wr_s & (off_s == OFF_CTRL);
  assign wr_count_s   = wr_s & (off_s == OFF_COUNT);
  assign wr_compare_s = wr_s & (off_s == OFF_COMPARE);
  assign wr_status_s  = wr_s & (off_s == OFF_STATUS);

  // Tick and flag-set decisions are taken on the pre-update COUNT/COMPARE.
  assign tick_s      = en_r & (pcnt_r == prescale_r);
  assign hit_s       = (count_r == compare_r);
  assign match_set_s = tick_s & hit_s;
  assign ovf_set_s   = tick_s & ~hit_s & (count_r == 32'hFFFF_FFFF);

  // Counter next value: bus write wins, then tick behaviour.
  always_comb begin
    count_next_s = count_r;
    if (wr_count_s) begin
      count_next_s = data_store;
    end else if (tick_s) begin
      if (hit_s && auto_r) begin
        count_next_s = 32'd0;
      end else begin
        count_next_s = count_r + 32'd1;
      end
    end else begin
      count_next_s = count_r;
    end
  end

  // Read mux over the current register values.
  always_comb begin
    rdata_s = 32'd0;
    case (off_s)
      OFF_CTRL:    rdata_s = {16'd0, prescale_r, 5'd0, irq_en_r, auto_r, en_r};
      OFF_COUNT:   rdata_s = count_r;
      OFF_COMPARE: rdata_s = compare_r;
      OFF_STATUS:  rdata_s = {30'd0, ovf_r, match_r};
      OFF_ID:      rdata_s = ID_VALUE;
      default:     rdata_s = 32'd0;
    endcase
  end

  // Control, compare and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_r       <= 1'b0;
      auto_r     <= 1'b0;
      irq_en_r   <= 1'b0;
      prescale_r <= 8'd0;
      compare_r  <= 32'd0;
      count_r    <= 32'd0;
    end else begin
      if (wr_ctrl_s) begin
        en_r       <= data_store[0];
        auto_r     <= data_store[1];
        irq_en_r   <= data_store[2];
        prescale_r <= data_store[15:8];
      end
      if (wr_compare_s) begin
        compare_r <= data_store;
      end
      count_r <= count_next_s;
    end
  end

  // Prescaler restarts on a COUNT write, on disable and after each tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_r <= 8'd0;
    end else if (wr_count_s || (wr_ctrl_s && !data_store[0]) || !en_r || tick_s) begin
      pcnt_r <= 8'd0;
    end else begin
      pcnt_r <= pcnt_r + 8'd1;
    end
  end

  // Sticky W1C flags; a hardware set in the same cycle beats the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      match_r <= match_set_s | (match_r & ~(wr_status_s & data_store[0]));
      ovf_r   <= ovf_set_s   | (ovf_r   & ~(wr_status_s & data_store[1]));
    end
  end

  // Registered read data and interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_fetch_r <= 32'd0;
      irq_r        <= 1'b0;
    end else begin
      data_fetch_r <= rd_s ? rdata_s : 32'd0;
      irq_r        <= irq_en_r & (match_r | ovf_r);
    end
  end

  assign data_fetch = data_fetch_r;
  assign irq        = irq_r;

endmodule

// File: tb/tb_mmio_timer_v1.sv
// Directed bench for mmio_timer_v1: per-cycle expected read data goes through a
// scoreboard queue; irq and reset behaviour are checked directly.
module tb_mmio_timer_v1;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic [31:0] data_address;
  logic [31:0] data_store;
  logic        data_read;
  logic        data_enable;
  logic [31:0] data_fetch;
  logic        irq;

  int vectors;
  int miscompares;
  logic [31:0] exp_q[$];

  localparam logic [31:0] ID = 32'h544D5231;

  mmio_timer_v1 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sel          (sel),
    .data_address (data_address),
    .data_store   (data_store),
    .data_read    (data_read),
    .data_enable  (data_enable),
    .data_fetch   (data_fetch),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_irq(input logic exp, input string tag);
    vectors++;
    assert (irq === exp) else begin
      miscompares++;
      $error("FAIL %s: observed irq=%b expected irq=%b", tag, irq, exp);
    end
  endtask

  // One bus cycle: drive at negedge, expect data_fetch at the following negedge.
  task automatic cyc(input logic s, input logic e, input logic r, input logic [7:0] off,
                     input logic [31:0] d, input logic [31:0] exp, input string tag);
    logic [31:0] want;
    sel          = s;
    data_enable  = e;
    data_read    = r;
    data_address = {22'd0, off, 2'b00};
    data_store   = d;
    exp_q.push_back(exp);
    @(negedge clk);
    want = exp_q.pop_front();
    check32(data_fetch, want, tag);
    sel         = 1'b0;
    data_enable = 1'b0;
    data_read   = 1'b0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    cyc(1'b1, 1'b1, 1'b0, off, d, 32'd0, "write_fetch_zero");
  endtask

  task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string tag);
    cyc(1'b1, 1'b1, 1'b1, off, 32'd0, exp, tag);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 32'd0, 32'd0, "idle_fetch_zero");
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    sel          = 1'b0;
    data_enable  = 1'b0;
    data_read    = 1'b0;
    data_address = 32'd0;
    data_store   = 32'd0;
    #2;
    check32(data_fetch, 32'd0, "reset_fetch");
    chk_irq(1'b0, "reset_irq");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset values of every offset
    rd(8'h00, 32'd0, "rst_ctrl");
    rd(8'h01, 32'd0, "rst_count");
    rd(8'h02, 32'd0, "rst_compare");
    rd(8'h03, 32'd0, "rst_status");
    rd(8'h04, ID,    "rst_id");
    rd(8'h05, 32'd0, "rst_unmapped");
    chk_irq(1'b0, "rst_irq_idle");

    // Auto-reload wrap at COMPARE=3, prescale 0
    wr(8'h02, 32'd3);
    wr(8'h00, 32'h3);
    rd(8'h01, 32'd0, "ar_count0");
    rd(8'h01, 32'd1, "ar_count1");
    rd(8'h01, 32'd2, "ar_count2");
    rd(8'h01, 32'd3, "ar_count3");
    rd(8'h01, 32'd0, "ar_wrap0");
    rd(8'h03, 32'd1, "ar_match");
    chk_irq(1'b0, "ar_irq_masked");
    wr(8'h00, 32'h0);
    rd(8'h01, 32'd3, "dis_count_tick_done");
    rd(8'h01, 32'd3, "dis_count_frozen");
    wr(8'h03, 32'h1);
    rd(8'h03, 32'd0, "w1c_match");

    // Overflow with IRQ_EN
    wr(8'h01, 32'hFFFF_FFFE);
    wr(8'h02, 32'h10);
    wr(8'h00, 32'h5);
    idle();
    idle();
    chk_irq(1'b0, "ovf_irq_not_yet");
    rd(8'h03, 32'd2, "ovf_status");
    chk_irq(1'b1, "ovf_irq_set");
    wr(8'h03, 32'h2);
    chk_irq(1'b1, "ovf_irq_lag");
    idle();
    chk_irq(1'b0, "ovf_irq_clear");
    rd(8'h03, 32'd0, "ovf_cleared");
    wr(8'h00, 32'h0);

    // Prescale 3: one step every 4 cycles, and pcnt restarts on disable
    wr(8'h01, 32'd0);
    wr(8'h00, 32'h0301);
    rd(8'h00, 32'h0301, "ps_ctrl_rb");
    idle();
    idle();
    rd(8'h01, 32'd0, "ps_count_hold");
    idle();
    idle();
    idle();
    rd(8'h01, 32'd1, "ps_count1");
    rd(8'h01, 32'd2, "ps_count2");
    wr(8'h00, 32'h0300);
    for (int i = 0; i < 5; i++) idle();
    rd(8'h01, 32'd2, "ps_frozen");
    wr(8'h00, 32'h0301);
    idle();
    idle();
    idle();
    rd(8'h01, 32'd2, "ps_reen_full_wait");
    rd(8'h01, 32'd3, "ps_reen_step");
    wr(8'h00, 32'h0);

    // W1C of MATCH in the cycle a tick sets it
    wr(8'h02, 32'd2);
    wr(8'h01, 32'd0);
    wr(8'h00, 32'h3);
    idle();
    idle();
    wr(8'h03, 32'h1);
    wr(8'h00, 32'h0);
    rd(8'h03, 32'd1, "set_beats_w1c");
    wr(8'h03, 32'h1);
    rd(8'h03, 32'd0, "w1c_alone");
    rd(8'h01, 32'd1, "ar_count_after");

    // COUNT write during a tick; MATCH uses the pre-write count
    wr(8'h00, 32'h1);
    idle();
    wr(8'h01, 32'h0000_ABCD);
    wr(8'h00, 32'h0);
    rd(8'h01, 32'h0000_ABCE, "wr_beats_tick");
    rd(8'h03, 32'd1, "match_prewrite");
    wr(8'h04, 32'd0);
    rd(8'h04, ID, "id_readonly");

    // Unselected / unstrobed accesses
    cyc(1'b0, 1'b1, 1'b0, 8'h01, 32'h55, 32'd0, "nosel_write");
    cyc(1'b1, 1'b0, 1'b0, 8'h01, 32'h55, 32'd0, "noen_write");
    cyc(1'b0, 1'b1, 1'b1, 8'h01, 32'd0,  32'd0, "nosel_read");
    rd(8'h01, 32'h0000_ABCE, "nosel_count_kept");

    // Asynchronous reset mid-count with a read in flight
    wr(8'h00, 32'h5);
    idle();
    chk_irq(1'b1, "pre_reset_irq");
    sel          = 1'b1;
    data_enable  = 1'b1;
    data_read    = 1'b1;
    data_address = 32'h4;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check32(data_fetch, 32'd0, "async_rst_fetch");
    chk_irq(1'b0, "async_rst_irq");
    sel         = 1'b0;
    data_enable = 1'b0;
    data_read   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd(8'h01, 32'd0, "post_rst_count");
    rd(8'h03, 32'd0, "post_rst_status");
    rd(8'h00, 32'd0, "post_rst_ctrl");
    chk_irq(1'b0, "post_rst_irq");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mmio_timer_v1.md
# mmio_timer_v1

Memory-mapped timer peripheral that responds on one 1 KiB MMIO slot selected by the SoC MMIO decoder's `mmio_vector[i]` line. It decodes word offsets within its slot and services single-cycle register writes and one-cycle-latency register reads. It runs a 32-bit prescaled up-counter with a compare match and an overflow detector, and raises a level interrupt. Read data is flopped so the SoC top can mux it with the pipelined select in the write-back stage.

## Interface
- `ID_VALUE`, default 32'h544D5231: constant returned by the ID register.
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `sel` input 1: slot select from the decoder's `mmio_vector[i]`; already qualified by `data_enable` and the MMIO range.
- `data_address` input 32: byte address; only `[9:2]` is used as the word offset, `[1:0]` are ignored.
- `data_store` input 32: write data.
- `data_read` input 1: 1 = read, 0 = write.
- `data_enable` input 1: access strobe.
- `data_fetch` output 32: registered read data.
- `irq` output 1: level interrupt.

## Operation
- Access condition: `acc = sel & data_enable`. Write when `acc & ~data_read`; read when `acc & data_read`. Only full-word writes are supported.
- Register map (word offset = `data_address[9:2]`):
  - 0x00 CTRL (RW): bit0 EN; bit1 AUTO_RELOAD; bit2 IRQ_EN; bits[15:8] PRESCALE. All other bits read 0.
  - 0x01 COUNT (RW).
  - 0x02 COMPARE (RW).
  - 0x03 STATUS: bit0 MATCH, bit1 OVF. Both are write-1-to-clear; writing 0 has no effect.
  - 0x04 ID (RO): returns `ID_VALUE`.
  - All other offsets: read 0; writes are ignored.
- Prescaler: 8-bit `pcnt`.
  - While EN=1: if `pcnt == PRESCALE`, generate a tick and set `pcnt <= 0`; otherwise `pcnt <= pcnt + 1`.
  - While EN=0: `pcnt` holds 0 and no tick is generated.
  - A tick therefore occurs every PRESCALE+1 enabled cycles.
- On a tick, evaluated on the current (pre-update) COUNT:
  - If COUNT == COMPARE: set MATCH. If AUTO_RELOAD=1, COUNT <= 0; otherwise COUNT <= COUNT+1.
  - Else if COUNT == 32'hFFFFFFFF: COUNT <= 0 and set OVF. Arithmetic is modulo 2^32.
  - Else: COUNT <= COUNT+1.
- `irq = IRQ_EN & (MATCH | OVF)`, driven from flops only, with no combinational path from the bus.
- Reads have no side effects.

## Timing
- Reset values: CTRL, COUNT, COMPARE, MATCH, OVF, `pcnt`, `data_fetch`, and `irq` are all 0.
- Write at edge E: the register holds the new value after E.
- CTRL write setting EN at edge E: COUNT increments at edges E+k·(PRESCALE+1), for k ≥ 1.
- Read in cycle N: `data_fetch` shows the register value as of the start of cycle N, from edge N+1 for one cycle. In any cycle with no read in the previous cycle, `data_fetch` is 0.
- Simultaneous events:
  - COUNT write and tick in the same cycle: the written value wins. MATCH and OVF from that tick still set, using the pre-write COUNT. The write also resets `pcnt` to 0.
  - W1C and hardware set of the same flag in the same cycle: set wins, and the flag stays 1.
  - CTRL write clearing EN: `pcnt` is 0 after the edge. No tick occurs in that cycle if `pcnt ≠ PRESCALE`; if `pcnt == PRESCALE`, the tick completes.
  - COMPARE write in a tick cycle: the tick compares against the old COMPARE.
- `irq` updates one cycle after a flag or IRQ_EN changes.
- Reset mid-operation: all state returns immediately (asynchronously) to reset values, and any in-flight read returns 0.
- `sel=0` or `data_enable=0`: no register changes from the bus, and `data_fetch` is 0 next cycle.

## Test plan
- Reset, then read each of offsets 0x00–0x05 -> CTRL, COUNT, COMPARE, and STATUS return 0; ID returns 32'h544D5231; 0x05 returns 0. `irq` is 0 throughout.
- COMPARE=3, CTRL=0x3 (EN, AUTO_RELOAD, PRESCALE 0) -> COUNT follows 0,1,2,3,0,1… one step per cycle. MATCH=1 after the 3->0 step; `irq` stays 0 because IRQ_EN=0.
- COUNT=0xFFFFFFFE, COMPARE=0x10, CTRL=0x5 -> after 2 ticks COUNT=0 and OVF=1; `irq`=1 one cycle later. Writing STATUS=0x2 -> OVF=0 and `irq`=0 next cycle.
- CTRL=0x0301 (PRESCALE=3) -> COUNT increments every 4 cycles. Clear EN -> COUNT freezes and `pcnt` reads back as 0 behaviour, i.e. the next enable waits the full 4 cycles.
- STATUS=0x1 written in the same cycle that a tick sets MATCH -> MATCH remains 1. COUNT write during a tick -> COUNT equals the written value.
- Write COUNT=0x55 with `sel=0`, then read with `sel=0` -> COUNT unchanged and `data_fetch`=0. Assert `rst_n` low mid-count -> all outputs 0 immediately.
